uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of byte entries; power of two, 2..256.
REQ-002 SHALL have parameter WATERMARK, default 12, level threshold used only when UART_RX_FIFO_WATERMARK_EN is defined.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rxByte  input  8  received byte from the UART receiver.
REQ-006 SHALL have port rxDv  input  1  one-cycle strobe; rxByte valid this cycle.
REQ-007 SHALL have port dataOut  output  8  head-of-queue byte, meaningful only while dataValid=1.
REQ-008 SHALL have port dataValid  output  1  FIFO non-empty; head presented on dataOut.
REQ-009 SHALL have port dataReady  input  1  consumer accepts head this cycle.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 SHALL have port full  output  1  count==DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky flag: byte dropped.
REQ-013 SHALL have port clearOverflow  input  1  synchronous clear of overflow.
REQ-014 SHALL have port levelIrq  output  1  present only with UART_RX_FIFO_WATERMARK_EN.

Function
REQ-015 SHALL be first-word-fall-through: dataOut = entry at read pointer; no read latency.
REQ-016 SHALL pop (advance read pointer, count-1) on a cycle with dataValid=1 and dataReady=1; dataReady while empty SHALL be ignored.
REQ-017 SHALL push rxByte (write pointer advance, count+1) on a cycle with rxDv=1 when not full.
REQ-018 SHALL make a pushed byte visible one cycle after rxDv: write to empty FIFO at edge N -> dataValid=1, dataOut=byte after edge N.
REQ-019 SHALL, on simultaneous push and pop, accept both and leave count unchanged, including when full (freed slot reused in same cycle) and when count==1.
REQ-020 SHALL, on rxDv=1 while full without pop, drop rxByte, leave pointers/count unchanged, and set overflow after that edge.
REQ-021 SHALL hold overflow at 1 until clearOverflow=1; clearOverflow coinciding with a new drop SHALL leave overflow=1 (set wins).
REQ-022 SHALL wrap read and write pointers from DEPTH-1 to 0; pointers width $clog2(DEPTH), count one bit wider.
REQ-023 SHALL derive dataValid = (count!=0) and full = (count==DEPTH) registered-consistent with count, never glitching between edges.

Reset
REQ-024 SHALL, while resetN=0, asynchronously force pointers=0, count=0, dataValid=0, full=0, overflow=0, levelIrq=0; storage contents not reset.
REQ-025 SHALL discard all queued bytes on reset asserted mid-operation; first rxDv after deassertion writes entry 0.

Configuration
REQ-026 SHALL, with UART_RX_FIFO_WATERMARK_EN defined, register levelIrq=1 in the cycle after count becomes >= WATERMARK, 0 after count < WATERMARK.
REQ-027 SHALL, without UART_RX_FIFO_WATERMARK_EN, omit levelIrq port and its logic entirely; all other behaviour identical.

Structure
REQ-028 SHALL take UART_BYTE_W (8) and the byte typedef from shared package uart_pkg.
REQ-029 SHALL place storage in sub-module uart_fifo_mem (DEPTH x 8, one synchronous write port, one asynchronous read port); pointer/count/flag control in uart_rx_fifo.

Verification
REQ-030 SHALL cover: reset, push 0xA5 -> next cycle dataValid=1, dataOut=0xA5, count=1; pop -> dataValid=0, count=0.
REQ-031 SHALL cover: push 0x00..0x0F with DEPTH=16, dataReady=0 -> full=1, count=16; drain -> bytes 0x00..0x0F in order.
REQ-032 SHALL cover: full, push 0xFF without pop -> count=16, overflow=1, 0xFF never appears; clearOverflow -> overflow=0.
REQ-033 SHALL cover: full, push 0x77 with simultaneous pop -> count=16, 0x77 emerges 16th after that pop; 40 pushes/pops exercise pointer wrap.
REQ-034 SHALL cover: resetN=0 with count=5 -> count=0, dataValid=0 immediately, no clock required.
REQ-035 SHALL cover (WATERMARK_EN, WATERMARK=12): 12th push -> levelIrq=1 next cycle; pop to 11 -> levelIrq=0 next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and byte type used across the receive path.
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
)
(
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  uart_byte_t               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output uart_byte_t               rdata
);

    // Contents are deliberately not reset; the control logic tracks validity.
    uart_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with sticky overflow flag.
// Define UART_RX_FIFO_WATERMARK_EN to add the registered levelIrq output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WATERMARK = 12
)
(
    input  logic                   clk,
    input  logic                   resetN,
    input  uart_byte_t             rxByte,
    input  logic                   rxDv,
    output uart_byte_t             dataOut,
    output logic                   dataValid,
    input  logic                   dataReady,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
`ifdef UART_RX_FIFO_WATERMARK_EN
    output logic                   levelIrq,
`endif
    input  logic                   clearOverflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two in 2..256");
    end
    if ((WATERMARK < 1) || (WATERMARK > DEPTH)) begin : g_bad_watermark
        $error("uart_rx_fifo: WATERMARK must lie in 1..DEPTH");
    end

    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          drop;

    uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (rxByte),
        .raddr (rptr),
        .rdata (dataOut)
    );

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    always_comb begin
        pop        = dataValid & dataReady;
        push       = rxDv & (~full | pop);
        drop       = rxDv & full & ~pop;
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            dataValid <= 1'b0;
            full      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            count     <= count_next;
            dataValid <= (count_next != '0);
            full      <= (count_next == CNT_FULL);
            if (drop) begin
                overflow <= 1'b1;
            end else if (clearOverflow) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_WATERMARK_EN
    localparam logic [CW-1:0] CNT_WM = CW'(WATERMARK);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            levelIrq <= 1'b0;
        end else begin
            levelIrq <= (count >= CNT_WM);
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16); levelIrq checks run when UART_RX_FIFO_WATERMARK_EN is defined.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       resetN;
    uart_byte_t rxByte;
    logic       rxDv;
    uart_byte_t dataOut;
    logic       dataValid;
    logic       dataReady;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic       clearOverflow;
`ifdef UART_RX_FIFO_WATERMARK_EN
    logic       levelIrq;
`endif

    int total = 0;
    int bad   = 0;
    uart_byte_t q [$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .WATERMARK(12)) dut (
        .clk           (clk),
        .resetN        (resetN),
        .rxByte        (rxByte),
        .rxDv          (rxDv),
        .dataOut       (dataOut),
        .dataValid     (dataValid),
        .dataReady     (dataReady),
        .count         (count),
        .full          (full),
        .overflow      (overflow),
`ifdef UART_RX_FIFO_WATERMARK_EN
        .levelIrq      (levelIrq),
`endif
        .clearOverflow (clearOverflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_only(input uart_byte_t b);
        rxByte = b;
        rxDv   = 1'b1;
        tick();
        rxDv   = 1'b0;
    endtask

    task automatic pop_only();
        dataReady = 1'b1;
        tick();
        dataReady = 1'b0;
    endtask

    initial begin
        resetN        = 1'b0;
        rxByte        = '0;
        rxDv          = 1'b0;
        dataReady     = 1'b0;
        clearOverflow = 1'b0;

        // Reset state
        #2;
        chk("rst_count", count, 0);
        chk("rst_valid", dataValid, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
`ifdef UART_RX_FIFO_WATERMARK_EN
        chk("rst_irq", levelIrq, 0);
`endif
        #11;
        resetN = 1'b1;
        tick();

        // Single byte round trip, then dataReady while empty is ignored
        push_only(8'hA5);
        chk("a5_valid", dataValid, 1);
        chk("a5_data", dataOut, 8'hA5);
        chk("a5_count", count, 1);
        pop_only();
        chk("a5_pop_valid", dataValid, 0);
        chk("a5_pop_count", count, 0);
        pop_only();
        chk("empty_pop_count", count, 0);
        chk("empty_pop_valid", dataValid, 0);

        // Fill to DEPTH
        for (int i = 0; i < 15; i++) push_only(8'(i));
        chk("fill15_count", count, 15);
        chk("fill15_full", full, 0);
        push_only(8'h0F);
        chk("fill16_count", count, 16);
        chk("fill16_full", full, 1);
        chk("fill16_head", dataOut, 8'h00);

        // Drop while full; clear coinciding with a drop keeps the flag
        push_only(8'hFF);
        chk("drop_count", count, 16);
        chk("drop_ovf", overflow, 1);
        chk("drop_head", dataOut, 8'h00);
        clearOverflow = 1'b1;
        push_only(8'hFE);
        chk("clr_drop_ovf", overflow, 1);
        chk("clr_drop_count", count, 16);
        tick();
        clearOverflow = 1'b0;
        chk("clr_ovf", overflow, 0);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", dataOut, 32'(i));
            pop_only();
        end
        chk("drain_valid", dataValid, 0);
        chk("drain_count", count, 0);

        // Push with simultaneous pop while full
        for (int i = 0; i < 16; i++) push_only(8'(8'h10 + i));
        rxByte    = 8'h77;
        rxDv      = 1'b1;
        dataReady = 1'b1;
        tick();
        rxDv      = 1'b0;
        dataReady = 1'b0;
        chk("full_pp_count", count, 16);
        chk("full_pp_full", full, 1);
        chk("full_pp_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) begin
            chk("full_pp_data", dataOut, (i == 15) ? 32'h77 : 32'(8'h11 + i));
            pop_only();
        end
        chk("full_pp_empty", dataValid, 0);

        // Push with simultaneous pop at count==1
        push_only(8'h30);
        rxByte    = 8'h31;
        rxDv      = 1'b1;
        dataReady = 1'b1;
        tick();
        rxDv      = 1'b0;
        dataReady = 1'b0;
        chk("one_pp_count", count, 1);
        chk("one_pp_data", dataOut, 8'h31);
        pop_only();
        chk("one_pp_empty", count, 0);

        // Streaming traffic wrapping both pointers
        for (int i = 0; i < 40; i++) begin
            rxByte    = 8'(8'h40 + i);
            rxDv      = 1'b1;
            dataReady = ((i % 3) != 0);
            if (dataReady && q.size() != 0) begin
                chk("stream_head", dataOut, q[0]);
                void'(q.pop_front());
            end
            q.push_back(rxByte);
            tick();
            chk("stream_count", count, q.size());
        end
        rxDv      = 1'b0;
        dataReady = 1'b0;
        while (q.size() != 0) begin
            chk("stream_drain", dataOut, q[0]);
            void'(q.pop_front());
            pop_only();
        end
        chk("stream_empty", dataValid, 0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) push_only(8'(8'h50 + i));
        chk("pre_rst_count", count, 5);
        #2;
        resetN = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_valid", dataValid, 0);
        #2;
        resetN = 1'b1;
        push_only(8'h99);
        chk("post_rst_count", count, 1);
        chk("post_rst_data", dataOut, 8'h99);

`ifdef UART_RX_FIFO_WATERMARK_EN
        pop_only();
        for (int i = 0; i < 11; i++) push_only(8'(i));
        tick();
        chk("wm11_irq", levelIrq, 0);
        push_only(8'h0B);
        chk("wm12_count", count, 12);
        tick();
        chk("wm12_irq", levelIrq, 1);
        pop_only();
        chk("wm_pop_count", count, 11);
        tick();
        chk("wm_pop_irq", levelIrq, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
